// File: rtl/bin2bcd_seq_if.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq_if
//   Start/busy/done conversion bus for the sequential binary-to-BCD converter.
//
// Handshake: the requester raises start with bin_in valid. The converter takes
// it only when busy is low (idle or done cycle). busy stays high for exactly
// BIN_W cycles, then done pulses for one cycle. bcd_out/overflow change only at
// the edge that raises done and are held until the next done.
//
// Signals
//   start     master->slave  request a conversion
//   bin_in    master->slave  unsigned binary value, BIN_W bits
//   busy      slave->master  conversion in progress
//   done      slave->master  one-cycle pulse, result just updated
//   bcd_out   slave->master  4*DIGITS bits, digit k = bcd_out[4k+3:4k]
//   overflow  slave->master  last value exceeded 10^DIGITS-1
// ----------------------------------------------------------------------------
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Feeds the seven-segment decoders: each BCD digit drives one decoder.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          slave modport of bin2bcd_seq_if (start/bin_in/busy/done/
//                bcd_out/overflow)
//   o_dbg_state  out  current FSM state (0 = IDLE, 1 = SHIFT)
// ----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus,
  output logic          o_dbg_state
);

  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam int WRK_W = 4 * DIGITS;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BIN_W-1:0]   r_shift;
  logic [WRK_W-1:0]   r_work;
  logic               r_ovf_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WRK_W-1:0]   r_bcd;
  logic               r_overflow;
  logic               r_done;

  logic [WRK_W-1:0]   w_adj;
  logic [WRK_W-1:0]   w_work_nxt;
  logic               w_out_bit;
  logic               w_last;

  // Add-3 on every digit >= 5 before the shift; 4-bit wrap, no inter-digit carry.
  always_comb begin
    w_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = 4'(r_work[4*k +: 4] + 4'd3);
      else
        w_adj[4*k +: 4] = r_work[4*k +: 4];
    end
  end

  // Shift {digits, shift_reg} left by one: shift_reg MSB enters digit 0,
  // top digit MSB falls out and feeds the overflow accumulator.
  assign w_work_nxt = {w_adj[WRK_W-2:0], r_shift[BIN_W-1]};
  assign w_out_bit  = w_adj[WRK_W-1];
  assign w_last     = (r_cnt == CNT_W'(BIN_W - 1));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_work     <= '0;
      r_ovf_acc  <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin_in;
            r_work    <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_SHIFT: begin
          r_shift   <= r_shift << 1;
          r_work    <= w_work_nxt;
          r_ovf_acc <= r_ovf_acc | w_out_bit;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd      <= w_work_nxt;
            r_overflow <= r_ovf_acc | w_out_bit;
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  logic dbg_a;
  logic dbg_b;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if_a ();
  bin2bcd_seq_if #(.BIN_W(10), .DIGITS(3)) if_b ();

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (if_a.slave),
    .o_dbg_state (dbg_a)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (if_b.slave),
    .o_dbg_state (dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? if_a.busy : if_b.busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? if_a.done : if_b.done;
  endfunction

  function automatic logic [31:0] bcd_of(input int sel);
    return (sel == 0) ? 32'(if_a.bcd_out) : 32'(if_b.bcd_out);
  endfunction

  function automatic logic ovf_of(input int sel);
    return (sel == 0) ? if_a.overflow : if_b.overflow;
  endfunction

  // driver: caller is positioned at a negedge; start is applied here and
  // taken at the next posedge. Returns at the negedge where done is seen.
  task automatic conv(input string tag, input int sel, input logic [15:0] val,
                      input logic [31:0] exp_bcd, input logic exp_ovf,
                      input logic [31:0] hold_bcd, input logic hold_ovf, input int w);
    int busy_n   = 0;
    int done_at  = 0;
    int both     = 0;
    int hold_bad = 0;
    if (sel == 0) begin if_a.start = 1'b1; if_a.bin_in = val;       end
    else          begin if_b.start = 1'b1; if_b.bin_in = val[9:0];  end
    for (int c = 1; c <= w + 10 && done_at == 0; c++) begin
      @(negedge clk);
      if_a.start = 1'b0;
      if_b.start = 1'b0;
      if (busy_of(sel)) busy_n++;
      if (busy_of(sel) && done_of(sel)) both++;
      if (done_of(sel)) done_at = c;
      else if (bcd_of(sel) !== hold_bcd || ovf_of(sel) !== hold_ovf) hold_bad++;
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(w + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(w));
    check({tag, "_busy_and_done"}, 32'(both), 32'd0);
    check({tag, "_held"}, 32'(hold_bad), 32'd0);
    check({tag, "_bcd"}, bcd_of(sel), exp_bcd);
    check({tag, "_ovf"}, 32'(ovf_of(sel)), 32'(exp_ovf));
  endtask

  initial begin
    int dones;
    int busy_seen;
    rst_n       = 1'b0;
    if_a.start  = 1'b0;
    if_a.bin_in = '0;
    if_b.start  = 1'b0;
    if_b.bin_in = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(if_a.busy), 32'd0);
    check("rst_done", 32'(if_a.done), 32'd0);
    check("rst_bcd",  32'(if_a.bcd_out), 32'd0);
    check("rst_ovf",  32'(if_a.overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic conversions
    conv("zero",  0, 16'd0,     32'h00000, 1'b0, 32'h00000, 1'b0, 16);
    @(negedge clk);
    check("done_one_cycle", 32'(if_a.done), 32'd0);
    conv("max",   0, 16'd65535, 32'h65535, 1'b0, 32'h00000, 1'b0, 16);
    @(negedge clk);
    conv("v1234", 0, 16'd1234,  32'h01234, 1'b0, 32'h65535, 1'b0, 16);
    // start in the done cycle: accepted, previous result held meanwhile
    conv("in_done", 0, 16'd9,   32'h00009, 1'b0, 32'h01234, 1'b0, 16);
    @(negedge clk);

    // start pulses while busy with bin_in toggling
    dones = 0;
    if_a.start  = 1'b1;
    if_a.bin_in = 16'd4321;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if_a.done) dones++;
      if (if_a.busy) begin
        if_a.start  = 1'b1;
        if_a.bin_in = c[0] ? 16'hFFFF : 16'h0000;
      end else begin
        if_a.start  = 1'b0;
      end
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_bcd", 32'(if_a.bcd_out), 32'h04321);

    // reset mid-conversion
    if_a.start  = 1'b1;
    if_a.bin_in = 16'd777;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if_a.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(if_a.busy), 32'd0);
    check("abort_done", 32'(if_a.done), 32'd0);
    check("abort_bcd",  32'(if_a.bcd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    busy_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (if_a.done) dones++;
      if (if_a.busy) busy_seen++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_no_busy", 32'(busy_seen), 32'd0);

    // 10-bit input, 3 digits
    conv("b1023", 1, 16'd1023, 32'h023, 1'b1, 32'h000, 1'b0, 10);
    @(negedge clk);
    conv("b999",  1, 16'd999,  32'h999, 1'b0, 32'h023, 1'b1, 10);
    @(negedge clk);
    conv("b100",  1, 16'd100,  32'h100, 1'b0, 32'h999, 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
